snn_event_scheduler: RTL and testbench
======================================

// Module: snn_event_scheduler
// PURPOSE
//  Sequences the 16-neuron SNN core for each input event. It pops a sensor event, streams the
//  event's weight row from the weight memory into the PEs, and pulses accumulate. It then drains
//  every resulting spike, one per handshake, into the output FIFO.
//  It also arbitrates the weight memory between this read sequencer and a host write port.
// PARAMETERS
//  N_NEURONS  16  number of PEs; must be a power of 2
//  N_INPUTS   16  number of sensor input lines; must be a power of 2
//  WEIGHT_W   8   weight word width
//  NI_W = $clog2(N_INPUTS), NN_W = $clog2(N_NEURONS), ADDR_W = NI_W+NN_W   (localparams)
// PORTS
//  clock         in   1          sole clock; all flops on posedge
//  reset         in   1          asynchronous, active-high
//  ev_valid      in   1          sensor event available
//  ev_addr       in   NI_W       sensor input index of the event
//  ev_ready      out  1          event accepted when ev_valid && ev_ready
//  host_wr_req   in   1          host weight-write request
//  host_wr_addr  in   ADDR_W     {input_idx, neuron_idx}
//  host_wr_data  in   WEIGHT_W   weight value
//  host_wr_gnt   out  1          write performed this cycle
//  mem_raddr     out  ADDR_W     weight memory read address; synchronous memory, 1-cycle latency
//  mem_waddr     out  ADDR_W     weight memory write address
//  mem_wdata     out  WEIGHT_W   weight memory write data
//  mem_wen       out  1          weight memory write enable
//  pe_wen        out  N_NEURONS  one-hot PE weight-load strobe
//  accum_en      out  1          accumulate pulse to all PEs
//  spike         in   N_NEURONS  PE spike flags
//  spike_done    out  1          clears the selected PE spike; also the out-FIFO write enable
//  spike_sel     out  NN_W       index of the lowest set spike bit (FIFO data)
//  fifo_full     in   1          output FIFO full
//  busy          out  1          state != IDLE
//  ev_count      out  16         events accepted; saturates at 16'hFFFF
//  spk_count     out  16         spikes drained; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values:
//   - Every output is 0. State is IDLE. Counters are 0.
//   - Reset mid-operation abandons the event; PE state is not touched.
//  States: IDLE, LOAD, LOAD_TAIL, ACCUM, SETTLE, DRAIN, DRAIN_WAIT.
//  IDLE arbitration:
//   - host_wr_gnt = IDLE && host_wr_req. The host has priority.
//   - ev_ready = IDLE && !host_wr_req.
//   - mem_wen = host_wr_gnt. mem_waddr and mem_wdata pass through the host inputs.
//  Host writes outside IDLE are held off (gnt=0); the host keeps its request asserted.
//  Event load sequence (cycle 0 = accept):
//   - On accept: latch ev_addr, ev_count++, go to LOAD with col=0.
//   - LOAD: mem_raddr = {ev_q, col}; col++; after col=N_NEURONS-1, go to LOAD_TAIL.
//   - pe_wen[k] is asserted one cycle after raddr col=k was issued. The col counter is delayed by
//     a 1-stage pipe register to produce it.
//   - LOAD_TAIL asserts pe_wen[N-1] (the final delayed strobe) and goes to ACCUM.
//   - ACCUM: accum_en=1 for exactly one cycle, then SETTLE.
//   - SETTLE: one idle cycle for the PE spike flags to update, then DRAIN.
//   - Default N=16 timeline: raddr issued in cycles 1..16; pe_wen in cycles 2..17; accum_en in
//     cycle 18; first DRAIN in cycle 20.
//  Drain phase:
//   - DRAIN, spike == 0: go to IDLE.
//   - DRAIN, spike != 0 && !fifo_full: spike_done=1 and spike_sel=lowest set index for one cycle;
//     spk_count++; go to DRAIN_WAIT.
//   - DRAIN, spike != 0 && fifo_full: stall in DRAIN with spike_done=0; no spike is lost.
//   - DRAIN_WAIT: one cycle for the PE to clear, then DRAIN. At most one spike_done per 2 cycles.
//  Arithmetic and wrap rules:
//   - col wraps only through the state transition; it is never allowed to overflow silently.
//   - The counters saturate and never wrap.
//  spike_sel is held at its last value when spike_done=0.
// STRUCTURE
//  Shared package snn_pkg:
//   - sched_state_e enum
//   - N_NEURONS and N_INPUTS defaults
//   - WEIGHT_W
//  Sub-module: existing priority_encoder (lowest index wins) instantiated for spike_sel.
//  Everything else stays in one always_ff FSM plus combinational output decode.
// TESTING
//  1. Host write to addr 8'h35 with data 8'h7F while IDLE: host_wr_gnt=1 and mem_wen=1 in the
//     same cycle; ev_ready=0 that cycle.
//  2. ev_addr=3 accepted, spike stays 0: raddr runs 8'h30..8'h3F in cycles 1..16; pe_wen one-hot
//     1<<k in cycle k+2; accum_en only in cycle 18; back to IDLE by cycle 21; ev_count=1.
//  3. After accum, spike=16'h8011: spike_sel sequence 0, 4, 15 with spike_done spaced 2 cycles
//     apart; spk_count=3; then IDLE.
//  4. fifo_full=1 during DRAIN with spike=16'h0002: no spike_done while full; on release,
//     spike_done=1 with spike_sel=1 on the next DRAIN cycle.
//  5. Host request asserted during LOAD: host_wr_gnt stays 0 until IDLE, then 1 for one cycle;
//     the event sequence is unperturbed.
//  6. reset asserted in cycle 9 of LOAD: all outputs 0 asynchronously; after deassert, a new event
//     starts a fresh sequence at col 0; counters are 0.

Source files
------------

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
//   Shared definitions for the SNN core scheduler: default core dimensions,
//   weight word width, the scheduler state type and a saturating counter
//   increment used by the event and spike counters.
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int DEF_N_NEURONS = 16;
    localparam int DEF_N_INPUTS  = 16;
    localparam int DEF_WEIGHT_W  = 8;
    localparam int CNT_W         = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_TAIL,
        S_ACCUM,
        S_SETTLE,
        S_DRAIN,
        S_DRAIN_WAIT
    } sched_state_e;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder
//   Returns the index of the lowest set bit of req_i.
//   Ports:
//     req_i    WIDTH           request vector
//     idx_o    $clog2(WIDTH)   lowest set index (0 when nothing is set)
//     valid_o  1               at least one request bit is set
// -----------------------------------------------------------------------------
module priority_encoder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         req_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = ($clog2(WIDTH))'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snn_event_scheduler.sv
// -----------------------------------------------------------------------------
// snn_event_scheduler
//   Per-event sequencer for the SNN core. Accepts a sensor event, streams the
//   event's weight row out of the synchronous weight memory into the PEs,
//   pulses accumulate, then drains every resulting spike into the output FIFO
//   one handshake at a time. While idle it also grants host weight writes,
//   and the host wins over a simultaneous event.
//   Ports:
//     clock, reset              clock; asynchronous active-high reset
//     ev_valid/ev_addr/ev_ready sensor event handshake
//     host_wr_req/addr/data     host weight-write request
//     host_wr_gnt               write performed this cycle
//     mem_raddr                 weight read address {input_idx, neuron_idx}
//     mem_waddr/wdata/wen       weight memory write port
//     pe_wen                    one-hot PE weight-load strobe
//     accum_en                  accumulate pulse to all PEs
//     spike                     PE spike flags
//     spike_done/spike_sel      spike clear strobe and index; FIFO write
//     fifo_full                 output FIFO full
//     busy                      scheduler not idle
//     ev_count/spk_count        saturating event and spike counters
// -----------------------------------------------------------------------------
module snn_event_scheduler
    import snn_pkg::*;
#(
    parameter int  N_NEURONS = DEF_N_NEURONS,
    parameter int  N_INPUTS  = DEF_N_INPUTS,
    parameter int  WEIGHT_W  = DEF_WEIGHT_W,
    localparam int NI_W      = $clog2(N_INPUTS),
    localparam int NN_W      = $clog2(N_NEURONS),
    localparam int ADDR_W    = NI_W + NN_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ev_valid,
    input  logic [NI_W-1:0]      ev_addr,
    output logic                 ev_ready,
    input  logic                 host_wr_req,
    input  logic [ADDR_W-1:0]    host_wr_addr,
    input  logic [WEIGHT_W-1:0]  host_wr_data,
    output logic                 host_wr_gnt,
    output logic [ADDR_W-1:0]    mem_raddr,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [WEIGHT_W-1:0]  mem_wdata,
    output logic                 mem_wen,
    output logic [N_NEURONS-1:0] pe_wen,
    output logic                 accum_en,
    input  logic [N_NEURONS-1:0] spike,
    output logic                 spike_done,
    output logic [NN_W-1:0]      spike_sel,
    input  logic                 fifo_full,
    output logic                 busy,
    output logic [CNT_W-1:0]     ev_count,
    output logic [CNT_W-1:0]     spk_count
);

    localparam logic [NN_W-1:0]      LAST_COL = NN_W'(N_NEURONS - 1);
    localparam logic [N_NEURONS-1:0] PE_ONE   = {{(N_NEURONS-1){1'b0}}, 1'b1};

    sched_state_e         state_q, state_d;
    logic [NI_W-1:0]      ev_q, ev_d;
    logic [NN_W-1:0]      col_q, col_d;
    // Column pipe: the memory returns data one cycle after the read address,
    // so the PE strobe follows the column counter by one stage.
    logic                 pe_vld_q, pe_vld_d;
    logic [NN_W-1:0]      pe_col_q, pe_col_d;
    logic [NN_W-1:0]      sel_q, sel_d;
    logic [CNT_W-1:0]     ev_count_q, ev_count_d;
    logic [CNT_W-1:0]     spk_count_q, spk_count_d;

    logic [NN_W-1:0]      enc_idx;
    logic                 enc_valid;
    logic                 gnt_c, rdy_c, done_c, accum_c;
    logic [ADDR_W-1:0]    raddr_c;

    priority_encoder #(.WIDTH(N_NEURONS)) u_spike_enc (
        .req_i   (spike),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // NOTE: every signal gets a default before the case so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        ev_d        = ev_q;
        col_d       = col_q;
        pe_vld_d    = 1'b0;
        pe_col_d    = col_q;
        sel_d       = sel_q;
        ev_count_d  = ev_count_q;
        spk_count_d = spk_count_q;
        gnt_c       = 1'b0;
        rdy_c       = 1'b0;
        done_c      = 1'b0;
        accum_c     = 1'b0;
        raddr_c     = '0;

        case (state_q)
            S_IDLE: begin
                gnt_c = host_wr_req;
                rdy_c = !host_wr_req;
                if (ev_valid && rdy_c) begin
                    ev_d       = ev_addr;
                    ev_count_d = sat_inc(ev_count_q);
                    col_d      = '0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                raddr_c  = {ev_q, col_q};
                pe_vld_d = 1'b1;
                // The column returns to zero only through the state change,
                // never by silently overflowing.
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = S_LOAD_TAIL;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_LOAD_TAIL: state_d = S_ACCUM;
            S_ACCUM: begin
                accum_c = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: state_d = S_DRAIN;
            S_DRAIN: begin
                if (!enc_valid) begin
                    state_d = S_IDLE;
                end else if (!fifo_full) begin
                    done_c      = 1'b1;
                    sel_d       = enc_idx;
                    spk_count_d = sat_inc(spk_count_q);
                    state_d     = S_DRAIN_WAIT;
                end
            end
            S_DRAIN_WAIT: state_d = S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ev_q        <= '0;
            col_q       <= '0;
            pe_vld_q    <= 1'b0;
            pe_col_q    <= '0;
            sel_q       <= '0;
            ev_count_q  <= '0;
            spk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ev_q        <= ev_d;
            col_q       <= col_d;
            pe_vld_q    <= pe_vld_d;
            pe_col_q    <= pe_col_d;
            sel_q       <= sel_d;
            ev_count_q  <= ev_count_d;
            spk_count_q <= spk_count_d;
        end
    end

    // The idle-state grants depend directly on host inputs, so they are
    // masked while reset is held to keep every output at zero.
    assign host_wr_gnt = gnt_c && !reset;
    assign ev_ready    = rdy_c && !reset;
    assign mem_wen     = host_wr_gnt;
    assign mem_waddr   = reset ? '0 : host_wr_addr;
    assign mem_wdata   = reset ? '0 : host_wr_data;
    assign mem_raddr   = raddr_c;
    assign pe_wen      = pe_vld_q ? (PE_ONE << pe_col_q) : '0;
    assign accum_en    = accum_c;
    assign spike_done  = done_c;
    // Present the live index on the strobe cycle, hold it otherwise.
    assign spike_sel   = done_c ? enc_idx : sel_q;
    assign busy        = (state_q != S_IDLE);
    assign ev_count    = ev_count_q;
    assign spk_count   = spk_count_q;

endmodule

// File: tb/tb_snn_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_snn_event_scheduler
//   Directed and randomized bench for snn_event_scheduler with the default
//   16x16 core. The expected timeline of every event, the drain order and the
//   counter values come from a cycle-numbered model of the event sequence and
//   a simple PE model that sets spike flags on accumulate and clears the
//   flag named by each spike_done.
// -----------------------------------------------------------------------------
module tb_snn_event_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        ev_valid;
    logic [3:0]  ev_addr;
    logic        ev_ready;
    logic        host_wr_req;
    logic [7:0]  host_wr_addr;
    logic [7:0]  host_wr_data;
    logic        host_wr_gnt;
    logic [7:0]  mem_raddr;
    logic [7:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic [15:0] pe_wen;
    logic        accum_en;
    logic [15:0] spike;
    logic        spike_done;
    logic [3:0]  spike_sel;
    logic        fifo_full;
    logic        busy;
    logic [15:0] ev_count;
    logic [15:0] spk_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [15:0] exp_ev   = '0;
    logic [15:0] exp_spk  = '0;
    logic [3:0]  last_sel = '0;
    logic [15:0] pe_pending = '0;

    always #5 clock = ~clock;

    snn_event_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .ev_valid     (ev_valid),
        .ev_addr      (ev_addr),
        .ev_ready     (ev_ready),
        .host_wr_req  (host_wr_req),
        .host_wr_addr (host_wr_addr),
        .host_wr_data (host_wr_data),
        .host_wr_gnt  (host_wr_gnt),
        .mem_raddr    (mem_raddr),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wen      (mem_wen),
        .pe_wen       (pe_wen),
        .accum_en     (accum_en),
        .spike        (spike),
        .spike_done   (spike_done),
        .spike_sel    (spike_sel),
        .fifo_full    (fifo_full),
        .busy         (busy),
        .ev_count     (ev_count),
        .spk_count    (spk_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    // Advance one clock; the PE model reacts to what was sampled before it.
    task automatic adv();
        logic       d, a;
        logic [3:0] s;
        d = spike_done;
        a = accum_en;
        s = spike_sel;
        @(posedge clock);
        #1;
        if (a) spike = pe_pending;
        if (d) spike[s] = 1'b0;
    endtask

    // One complete event: accept (cycle 0), load row in cycles 1..16, strobes
    // in 2..17, accumulate in 18, settle in 19, drain from 20, then idle.
    task automatic run_event(input logic [3:0] e, input logic [15:0] pattern,
                             input bit host_during, input int first_stall,
                             input int full_pct);
        logic [15:0] remaining;
        logic [3:0]  lo;
        logic [7:0]  ha, hd;
        int          stall_left, consec;
        ha = 8'($urandom);
        hd = 8'($urandom);
        pe_pending  = pattern;
        host_wr_req = 1'b0;
        ev_valid    = 1'b1;
        ev_addr     = e;
        @(negedge clock);
        check("accept_ready", ev_ready, 1);
        check("accept_busy", busy, 0);
        adv();
        exp_ev = sat(exp_ev);
        for (int c = 1; c <= 19; c++) begin
            ev_valid = 1'($urandom);
            ev_addr  = 4'($urandom);
            if (host_during && c == 3) begin
                host_wr_req  = 1'b1;
                host_wr_addr = ha;
                host_wr_data = hd;
            end
            @(negedge clock);
            check("raddr", mem_raddr, (c <= 16) ? {e, 4'(c - 1)} : 8'h00);
            check("pe_wen", pe_wen, (c >= 2 && c <= 17) ? 16'(32'd1 << (c - 2)) : 16'h0);
            check("accum_en", accum_en, (c == 18));
            check("busy_seq", busy, 1);
            check("ready_seq", ev_ready, 0);
            check("gnt_held", host_wr_gnt, 0);
            check("wen_held", mem_wen, 0);
            check("done_seq", spike_done, 0);
            check("sel_hold_seq", spike_sel, last_sel);
            if (c == 1) check("ev_count_inc", ev_count, exp_ev);
            adv();
        end
        ev_valid   = 1'b0;
        remaining  = pattern;
        stall_left = first_stall;
        consec     = 0;
        forever begin
            if (stall_left > 0) begin
                fifo_full = 1'b1;
                stall_left--;
            end else if (consec >= 4) begin
                fifo_full = 1'b0;
            end else begin
                fifo_full = ($urandom_range(0, 99) < full_pct);
            end
            if (remaining == 16'h0) fifo_full = 1'($urandom);
            @(negedge clock);
            check("busy_drain", busy, 1);
            check("accum_drain", accum_en, 0);
            if (remaining == 16'h0 || fifo_full) begin
                check("no_done", spike_done, 0);
                check("sel_hold", spike_sel, last_sel);
                consec = consec + 1;
                adv();
                if (remaining == 16'h0) break;
            end else begin
                lo = lowest(remaining);
                check("done", spike_done, 1);
                check("sel", spike_sel, lo);
                last_sel      = lo;
                remaining[lo] = 1'b0;
                exp_spk       = sat(exp_spk);
                consec        = 0;
                adv();
                fifo_full = 1'($urandom);
                @(negedge clock);
                check("wait_done", spike_done, 0);
                check("wait_busy", busy, 1);
                check("wait_sel_hold", spike_sel, last_sel);
                adv();
            end
        end
        fifo_full = 1'b0;
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("ev_count", ev_count, exp_ev);
        check("spk_count", spk_count, exp_spk);
        if (host_during) begin
            check("late_gnt", host_wr_gnt, 1);
            check("late_wen", mem_wen, 1);
            check("late_waddr", mem_waddr, ha);
            check("late_wdata", mem_wdata, hd);
            check("late_ready", ev_ready, 0);
        end else begin
            check("idle_ready", ev_ready, 1);
        end
        adv();
        host_wr_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        ev_valid     = 1'b0;
        ev_addr      = '0;
        host_wr_req  = 1'b0;
        host_wr_addr = '0;
        host_wr_data = '0;
        spike        = '0;
        fifo_full    = 1'b0;
        #1;
        check("rst_ready", ev_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_raddr", mem_raddr, 0);
        check("rst_pe_wen", pe_wen, 0);
        check("rst_counts", {ev_count, spk_count}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Host write while idle beats a simultaneous event.
        host_wr_req  = 1'b1;
        host_wr_addr = 8'h35;
        host_wr_data = 8'h7F;
        ev_valid     = 1'b1;
        ev_addr      = 4'h5;
        @(negedge clock);
        check("host_gnt", host_wr_gnt, 1);
        check("host_wen", mem_wen, 1);
        check("host_waddr", mem_waddr, 8'h35);
        check("host_wdata", mem_wdata, 8'h7F);
        check("host_ready", ev_ready, 0);
        adv();
        host_wr_req = 1'b0;
        ev_valid    = 1'b0;
        @(negedge clock);
        check("host_no_accept", busy, 0);
        check("host_ev_count", ev_count, 0);
        check("host_gnt_drop", host_wr_gnt, 0);
        adv();

        // Quiet event, multi-spike drain, stalled drain, host held off.
        run_event(4'd3, 16'h0000, 1'b0, 0, 0);
        run_event(4'd9, 16'h8011, 1'b0, 0, 0);
        run_event(4'd6, 16'h0002, 1'b0, 3, 0);
        run_event(4'd12, 16'($urandom), 1'b1, 0, 0);

        // Reset in cycle 9 of the load sequence.
        pe_pending = 16'hFFFF;
        ev_valid   = 1'b1;
        ev_addr    = 4'hA;
        @(negedge clock);
        check("rst_seq_accept", ev_ready, 1);
        adv();
        ev_valid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            adv();
        end
        #1;
        check("pre_rst_raddr", mem_raddr, 8'hA8);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_raddr", mem_raddr, 0);
        check("mid_rst_pe_wen", pe_wen, 0);
        check("mid_rst_accum", accum_en, 0);
        check("mid_rst_ready", ev_ready, 0);
        check("mid_rst_gnt", {host_wr_gnt, mem_wen, mem_waddr, mem_wdata}, 0);
        check("mid_rst_done", {spike_done, spike_sel}, 0);
        check("mid_rst_counts", {ev_count, spk_count}, 0);
        @(negedge clock);
        adv();
        reset    = 1'b0;
        exp_ev   = '0;
        exp_spk  = '0;
        last_sel = '0;
        @(negedge clock);
        check("post_rst_counts", {ev_count, spk_count}, 0);
        check("post_rst_busy", busy, 0);
        adv();
        run_event(4'd7, 16'h0104, 1'b0, 0, 0);

        // Randomized events with random FIFO back-pressure.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] pat;
            case ($urandom_range(0, 3))
                0:       pat = 16'h0000;
                1:       pat = 16'hFFFF;
                default: pat = 16'($urandom);
            endcase
            run_event(4'($urandom), pat, 1'($urandom_range(0, 3) == 0),
                      $urandom_range(0, 2), 30);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
